tdm_slot_mux: RTL and testbench
===============================

# tdm_slot_mux

Parametrised N-channel, fixed-schedule time-division output multiplexer. It generalises the two-source, timer-LSB output select to NCH channels with configurable width and slot length. It adds per-channel one-entry buffering with valid/ready handshakes. It sits between several labelled producer datapaths and a single shared low-observable output. The slot schedule depends only on the free-running `{L}` slot counter, so one channel's traffic cannot modulate when another channel's data appears.

## Interface
- `WIDTH`, 16, data width per channel
- `NCH`, 4, channel count, ≥1
- `SLOT_LEN`, 1, cycles per slot, ≥1
- `CW`, `$clog2(NCH)` (min 1), channel-index width (derived)
- `clk`  in  1  `{L}` clock
- `rst_n`  in  1  `{L}` asynchronous active-low reset
- `in_data`  in  NCH*WIDTH  channel c at bits [c*WIDTH +: WIDTH]; labelled per channel
- `in_valid`  in  NCH  producer has data; bit c carries channel c's label
- `in_ready`  out  NCH  buffer c empty; bit c carries channel c's label
- `slot`  out  CW  `{L}` current slot index
- `out`  out  WIDTH  emitted word; label dependent on `out_ch`
- `out_valid`  out  1  `out` holds a word this cycle; label dependent on `out_ch`
- `out_ch`  out  CW  `{L}` channel of the current/last slot emission
- `slot_en`  in  NCH  `{L}`; only present with `TDM_SLOT_MASK_EN`

## Operation
- Registers: `slot` (0..NCH-1); `cyc` (0..SLOT_LEN-1); per channel `buf[c]`, `full[c]`; plus `out`, `out_valid`, `out_ch`.
- `cyc` increments each cycle and wraps to 0 after SLOT_LEN-1. On that wrap, `slot` increments mod NCH. NCH-1 → 0 wraps with no gap cycle.
- `in_ready[c] = !full[c]`, combinational from the register. An accept (`in_valid[c] & in_ready[c]`) writes `buf[c]` and sets `full[c]`.
- Emission: in a cycle with `cyc==0`, at the closing edge:
  - `out_ch <= slot`.
  - If `full[slot]`: `out <= buf[slot]`, `out_valid <= 1`, `full[slot] <= 0`.
  - Otherwise: `out <= 0`, `out_valid <= 0`.
- In all other cycles, `out_valid <= 0` and `out <= 0`. No stale data is ever visible.
- A full buffer is never overwritten. `in_valid` while full is ignored; the producer holds its data.
- Drain and new accept on the same channel cannot occur in one cycle, because `in_ready` is 0 while full. The new accept happens at the earliest the cycle after the drain.
- Accepts on different channels are independent and may be simultaneous.
- `out`, `out_valid` and `out_ch` change only at slot-start edges and at the edge that follows them.

## Timing
- Reset asserted, asynchronously:
  - `slot=0`, `cyc=0`, all `full=0`, `out=0`, `out_valid=0`, `out_ch=0`.
  - `in_ready` is all-ones.
  - Reset mid-slot discards buffered data; no emission follows.
- First cycle after `rst_n` rises: `slot=0`, `cyc=0`.
- Slot k spans cycles k*SLOT_LEN .. k*SLOT_LEN+SLOT_LEN-1 after reset, mod NCH*SLOT_LEN.
- Latency from accept on channel c to `out_valid`:
  - Measured to the first cycle with `slot==c` and `cyc==0` strictly after the accept cycle, plus 1 cycle.
  - Maximum is NCH*SLOT_LEN+1 cycles.
- An accept in the very `cyc==0` cycle of its own slot is not emitted this slot. The emission decision uses the registered `full`.
- `out_valid` pulses for exactly 1 cycle per emission. With NCH=1 and SLOT_LEN=1, back-to-back pulses are possible at 1 word per 2 cycles (accept, drain).
- Throughput per channel is at most 1 word per NCH*SLOT_LEN cycles.

## Configuration
- `TDM_SLOT_MASK_EN` defined: adds the `slot_en` input.
  - For a channel with `slot_en[c]=0`: `in_ready[c]` is forced to 0 and `full[c]` is cleared.
  - Its slot still elapses, with `out_valid=0` and `out=0`. The schedule never shrinks.
- `TDM_SLOT_MASK_EN` undefined: there is no `slot_en` port and all channels are always enabled.

## Test plan
Bench parameters: WIDTH=16, NCH=4, SLOT_LEN=2.
- Reset: drive `rst_n=0` mid-slot 2 with `full[2]=1` → immediately `out=0`, `out_valid=0`, `out_ch=0`, `slot=0`, `in_ready=4'b1111`. After release there is no emission of the lost word.
- Single word: accept 16'h00AB on ch2 in cycle 0 after reset → `out=16'h00AB`, `out_valid=1`, `out_ch=2` in cycle 5 only. `in_ready[2]=1` again from cycle 5.
- All channels: accept 16'h1000..16'h1003 on ch0..3 in cycle 1 → `out_valid` pulses in cycles 9 (ch0), 3 (ch1), 5 (ch2), 7 (ch3). Words match their channels; `out=0` in all other cycles.
- Back-pressure: accept 16'h0011 on ch1 in cycle 0, then present 16'h0022 in cycles 1-2 → `in_ready[1]=0`, `out=16'h0011` in cycle 3. 16'h0022 is accepted in cycle 3 and emitted in cycle 11.
- Wrap: run 20 cycles idle → `slot` sequence 0,0,1,1,2,2,3,3,0,… and `out_valid` stays 0 throughout.
- `TDM_SLOT_MASK_EN` with `slot_en=4'b1101`, pushing on ch1 → `in_ready[1]=0`, no emission in slot 1, and slot timing is unchanged.

Source files
------------

// File: rtl/tdm_slot_mux.sv
// Fixed-schedule N-channel TDM output mux with one-entry per-channel buffers; a word is emitted the cycle after its slot starts, and a full buffer holds its producer off.
// Build with TDM_SLOT_MASK_EN to add the slot_en input that disables individual channels without shrinking the schedule.
module tdm_slot_mux #(
   parameter int WIDTH    = 16,
   parameter int NCH      = 4,
   parameter int SLOT_LEN = 1,
   parameter int CW       = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NCH*WIDTH-1:0] in_data,
   input  logic [NCH-1:0]       in_valid,
   output logic [NCH-1:0]       in_ready,
   output logic [CW-1:0]        slot,
   output logic [WIDTH-1:0]     out,
   output logic                 out_valid,
   output logic [CW-1:0]        out_ch
`ifdef TDM_SLOT_MASK_EN
   ,input logic [NCH-1:0]       slot_en
`endif
);

   localparam int CYW = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;

   logic [CYW-1:0]   cyc_q, cyc_d;
   logic [CW-1:0]    slot_q, slot_d;
   logic [NCH-1:0]   full_q, full_d;
   logic [WIDTH-1:0] dbuf_q [NCH];
   logic [WIDTH-1:0] dbuf_d [NCH];
   logic [WIDTH-1:0] out_q, out_d;
   logic             out_valid_q, out_valid_d;
   logic [CW-1:0]    out_ch_q, out_ch_d;
   logic [NCH-1:0]   ch_en;

`ifdef TDM_SLOT_MASK_EN
   assign ch_en = slot_en;
`else
   assign ch_en = '1;
`endif

   assign in_ready  = ~full_q & ch_en;
   assign slot      = slot_q;
   assign out       = out_q;
   assign out_valid = out_valid_q;
   assign out_ch    = out_ch_q;

   always_comb begin
      cyc_d       = cyc_q;
      slot_d      = slot_q;
      full_d      = full_q;
      dbuf_d      = dbuf_q;
      out_d       = '0;
      out_valid_d = 1'b0;
      out_ch_d    = out_ch_q;

      // Schedule advances from the free-running counter only, never from traffic.
      if (cyc_q == CYW'(SLOT_LEN - 1)) begin
         cyc_d  = '0;
         slot_d = (slot_q == CW'(NCH - 1)) ? '0 : slot_q + CW'(1);
      end else begin
         cyc_d = cyc_q + CYW'(1);
      end

      if (cyc_q == '0) begin
         out_ch_d = slot_q;
         if (full_q[slot_q]) begin
            out_d          = dbuf_q[slot_q];
            out_valid_d    = 1'b1;
            full_d[slot_q] = 1'b0;
         end
      end

      // in_ready is low while full, so an accept never collides with a drain.
      for (int c = 0; c < NCH; c++) begin
         if (in_valid[c] && in_ready[c]) begin
            full_d[c] = 1'b1;
            dbuf_d[c] = in_data[c*WIDTH +: WIDTH];
         end
         if (!ch_en[c]) begin
            full_d[c] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc_q       <= '0;
         slot_q      <= '0;
         full_q      <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         out_ch_q    <= '0;
         for (int c = 0; c < NCH; c++) begin
            dbuf_q[c] <= '0;
         end
      end else begin
         cyc_q       <= cyc_d;
         slot_q      <= slot_d;
         full_q      <= full_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         out_ch_q    <= out_ch_d;
         for (int c = 0; c < NCH; c++) begin
            dbuf_q[c] <= dbuf_d[c];
         end
      end
   end

endmodule

// File: tb/tb_tdm_slot_mux.sv
// Directed bench for tdm_slot_mux with WIDTH=16, NCH=4, SLOT_LEN=2; cycle k starts at the negedge where rst_n rises.
module tb_tdm_slot_mux;
   localparam int WIDTH    = 16;
   localparam int NCH      = 4;
   localparam int SLOT_LEN = 2;
   localparam int CW       = 2;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic [NCH*WIDTH-1:0] in_data = '0;
   logic [NCH-1:0]       in_valid = '0;
   logic [NCH-1:0]       in_ready;
   logic [CW-1:0]        slot;
   logic [WIDTH-1:0]     out;
   logic                 out_valid;
   logic [CW-1:0]        out_ch;
`ifdef TDM_SLOT_MASK_EN
   logic [NCH-1:0]       slot_en = 4'b1111;
`endif

   int total = 0;
   int bad   = 0;

   tdm_slot_mux #(.WIDTH(WIDTH), .NCH(NCH), .SLOT_LEN(SLOT_LEN), .CW(CW)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_data(in_data),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .slot(slot),
      .out(out),
      .out_valid(out_valid),
      .out_ch(out_ch)
`ifdef TDM_SLOT_MASK_EN
      ,.slot_en(slot_en)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  vld;
      logic [63:0] dat;
      logic [1:0]  eslot;
      logic        evld;
      logic [15:0] eout;
      logic [1:0]  ech;
      logic [3:0]  erdy;
   } vec_t;

   vec_t tab [11];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Leaves the bench at the negedge where rst_n rises, i.e. the start of cycle 0.
   task automatic do_reset();
      @(negedge clk);
      rst_n    = 1'b0;
      in_valid = '0;
      in_data  = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      tab[0]  = '{4'b0000, 64'h0, 2'd0, 1'b0, 16'h0000, 2'd0, 4'b1111};
      tab[1]  = '{4'b1111, 64'h1003_1002_1001_1000, 2'd0, 1'b0, 16'h0000, 2'd0, 4'b1111};
      tab[2]  = '{4'b0000, 64'h0, 2'd1, 1'b0, 16'h0000, 2'd0, 4'b0000};
      tab[3]  = '{4'b0000, 64'h0, 2'd1, 1'b1, 16'h1001, 2'd1, 4'b0010};
      tab[4]  = '{4'b0000, 64'h0, 2'd2, 1'b0, 16'h0000, 2'd1, 4'b0010};
      tab[5]  = '{4'b0000, 64'h0, 2'd2, 1'b1, 16'h1002, 2'd2, 4'b0110};
      tab[6]  = '{4'b0000, 64'h0, 2'd3, 1'b0, 16'h0000, 2'd2, 4'b0110};
      tab[7]  = '{4'b0000, 64'h0, 2'd3, 1'b1, 16'h1003, 2'd3, 4'b1110};
      tab[8]  = '{4'b0000, 64'h0, 2'd0, 1'b0, 16'h0000, 2'd3, 4'b1110};
      tab[9]  = '{4'b0000, 64'h0, 2'd0, 1'b1, 16'h1000, 2'd0, 4'b1111};
      tab[10] = '{4'b0000, 64'h0, 2'd1, 1'b0, 16'h0000, 2'd0, 4'b1111};

      // Reset state while rst_n is still low
      @(negedge clk);
      chk("rst_out", 32'(out), 32'h0);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_out_ch", 32'(out_ch), 32'h0);
      chk("rst_slot", 32'(slot), 32'h0);
      chk("rst_in_ready", 32'(in_ready), 32'hF);

      // All channels accepted in cycle 1
      do_reset();
      for (int k = 0; k < 11; k++) begin
         in_valid = tab[k].vld;
         in_data  = tab[k].dat;
         #1;
         chk($sformatf("tab%0d_slot", k), 32'(slot), 32'(tab[k].eslot));
         chk($sformatf("tab%0d_vld", k), 32'(out_valid), 32'(tab[k].evld));
         chk($sformatf("tab%0d_out", k), 32'(out), 32'(tab[k].eout));
         chk($sformatf("tab%0d_ch", k), 32'(out_ch), 32'(tab[k].ech));
         chk($sformatf("tab%0d_rdy", k), 32'(in_ready), 32'(tab[k].erdy));
         @(negedge clk);
      end

      // Single word on ch2 accepted in cycle 0
      do_reset();
      for (int k = 0; k < 9; k++) begin
         in_valid = (k == 0) ? 4'b0100 : 4'b0000;
         in_data  = 64'h0000_00AB_0000_0000;
         #1;
         chk($sformatf("single%0d_vld", k), 32'(out_valid), (k == 5) ? 32'h1 : 32'h0);
         chk($sformatf("single%0d_out", k), 32'(out), (k == 5) ? 32'h00AB : 32'h0);
         chk($sformatf("single%0d_rdy2", k), 32'(in_ready[2]), (k == 0 || k >= 5) ? 32'h1 : 32'h0);
         if (k == 5) chk("single_ch", 32'(out_ch), 32'h2);
         @(negedge clk);
      end

      // Back-pressure on ch1: second word held until the drain cycle
      do_reset();
      for (int k = 0; k < 13; k++) begin
         in_valid = (k <= 3) ? 4'b0010 : 4'b0000;
         in_data  = (k == 0) ? 64'h0000_0000_0011_0000 : 64'h0000_0000_0022_0000;
         #1;
         chk($sformatf("bp%0d_rdy1", k), 32'(in_ready[1]),
             (k == 0 || k == 3 || k >= 11) ? 32'h1 : 32'h0);
         chk($sformatf("bp%0d_vld", k), 32'(out_valid), (k == 3 || k == 11) ? 32'h1 : 32'h0);
         chk($sformatf("bp%0d_out", k), 32'(out),
             (k == 3) ? 32'h0011 : (k == 11) ? 32'h0022 : 32'h0);
         @(negedge clk);
      end

      // Idle wrap of the schedule
      do_reset();
      for (int k = 0; k < 20; k++) begin
         #1;
         chk($sformatf("wrap%0d_slot", k), 32'(slot), 32'((k / SLOT_LEN) % NCH));
         chk($sformatf("wrap%0d_vld", k), 32'(out_valid), 32'h0);
         @(negedge clk);
      end

      // Reset mid-slot 2 while ch2 holds a word
      do_reset();
      in_valid = 4'b0100;
      in_data  = 64'h0000_5A5A_0000_0000;
      @(negedge clk);
      in_valid = 4'b0000;
      repeat (3) @(negedge clk);
      #1;
      chk("mid_pre_slot", 32'(slot), 32'h2);
      chk("mid_pre_full2", 32'(in_ready[2]), 32'h0);
      chk("mid_pre_ch", 32'(out_ch), 32'h1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out", 32'(out), 32'h0);
      chk("mid_rst_vld", 32'(out_valid), 32'h0);
      chk("mid_rst_ch", 32'(out_ch), 32'h0);
      chk("mid_rst_slot", 32'(slot), 32'h0);
      chk("mid_rst_rdy", 32'(in_ready), 32'hF);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         #1;
         chk($sformatf("mid_post%0d_vld", k), 32'(out_valid), 32'h0);
         @(negedge clk);
      end

`ifdef TDM_SLOT_MASK_EN
      // Channel 1 disabled: no accept, no emission, schedule unchanged
      slot_en = 4'b1101;
      do_reset();
      for (int k = 0; k < 10; k++) begin
         in_valid = 4'b0010;
         in_data  = 64'h0000_0000_0077_0000;
         #1;
         chk($sformatf("mask%0d_rdy1", k), 32'(in_ready[1]), 32'h0);
         chk($sformatf("mask%0d_vld", k), 32'(out_valid), 32'h0);
         chk($sformatf("mask%0d_slot", k), 32'(slot), 32'((k / SLOT_LEN) % NCH));
         @(negedge clk);
      end
      in_valid = 4'b0000;
      slot_en  = 4'b1111;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
